// File: rtl/sc_sevenseg_pkg.sv
// Shared types, segment table and sizing helper for the seven-segment sequencer.
package sc_sevenseg_pkg;

  // Playback phases of one display sequence.
  typedef enum logic [2:0] {
    StIdle,
    StShowHi,
    StGapHi,
    StShowLo,
    StGapLo
  } seq_state_e;

  // Hex glyphs, bit order {g,f,e,d,c,b,a}, 1 = lit. Entry 15 is written first.
  localparam logic [15:0][6:0] SegTable = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Counter width able to hold max(a, b) - 1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sc_hex_to_7seg.sv
// Combinational 4-bit hex digit to seven-segment glyph decode.
module sc_hex_to_7seg
  import sc_sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] segments_o
);

  // Plain table lookup.
  always_comb begin
    segments_o = SegTable[nibble_i];
  end

endmodule

// File: rtl/sc_sevenseg_sequencer.sv
// Captures an 8-bit value on a show request and plays it on one seven-segment
// digit: high nibble, gap, low nibble, gap, then back to blank idle.
module sc_sevenseg_sequencer
  import sc_sevenseg_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS = 25000000,
  parameter int unsigned GAP_TICKS   = 5000000
) (
  input  logic       SC_SEVENSEG_CLOCK_50,
  input  logic       SC_SEVENSEG_RESET_InLow,
  input  logic [7:0] SC_SEVENSEG_data_InBUS,
  input  logic       SC_SEVENSEG_show_InLow,
  output logic [6:0] SC_SEVENSEG_segments_OutBUS,
  output logic       SC_SEVENSEG_dp_Out,
  output logic       SC_SEVENSEG_busy_Out
);

  localparam int unsigned CntW = cnt_width(DIGIT_TICKS, GAP_TICKS);
  localparam logic [CntW-1:0] DigitLast = CntW'(DIGIT_TICKS - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(GAP_TICKS - 1);

  seq_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      shadow_q, shadow_d;
  logic            show_prev_q;
  logic            armed_q;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            busy_q, busy_d;

  logic            start;
  logic            phase_last;
  logic [3:0]      nibble_sel;
  logic [6:0]      nibble_seg;

  // A request held low through reset must not fire on release, so the edge
  // detector only arms once the request line has been seen high.
  assign start = (state_q == StIdle) && armed_q && show_prev_q && !SC_SEVENSEG_show_InLow;

  // Request edge detector and arming flag.
  always_ff @(posedge SC_SEVENSEG_CLOCK_50 or negedge SC_SEVENSEG_RESET_InLow) begin
    if (!SC_SEVENSEG_RESET_InLow) begin
      show_prev_q <= 1'b1;
      armed_q     <= 1'b0;
    end else begin
      show_prev_q <= SC_SEVENSEG_show_InLow;
      armed_q     <= armed_q | SC_SEVENSEG_show_InLow;
    end
  end

  // FSM state, phase counter and captured value.
  always_ff @(posedge SC_SEVENSEG_CLOCK_50 or negedge SC_SEVENSEG_RESET_InLow) begin
    if (!SC_SEVENSEG_RESET_InLow) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shadow_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  // Next-state: start from idle, otherwise count out each timed phase.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    phase_last = ((state_q == StShowHi) || (state_q == StShowLo)) ? (cnt_q == DigitLast)
                                                                  : (cnt_q == GapLast);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StShowHi;
          cnt_d    = '0;
          shadow_d = SC_SEVENSEG_data_InBUS;
        end
      end
      StShowHi, StGapHi, StShowLo, StGapLo: begin
        if (phase_last) begin
          cnt_d = '0;
          unique case (state_q)
            StShowHi: state_d = StGapHi;
            StGapHi:  state_d = StShowLo;
            StShowLo: state_d = StGapLo;
            default:  state_d = StIdle;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Single decoder shared by both nibbles; fed from next state so the
  // registered outputs line up with the state they describe.
  assign nibble_sel = (state_d == StShowLo) ? shadow_d[3:0] : shadow_d[7:4];

  sc_hex_to_7seg u_hex_to_7seg (
    .nibble_i   (nibble_sel),
    .segments_o (nibble_seg)
  );

  // Output decode from next state.
  always_comb begin
    seg_d  = 7'h00;
    dp_d   = 1'b0;
    busy_d = (state_d != StIdle);
    if ((state_d == StShowHi) || (state_d == StShowLo)) begin
      seg_d = nibble_seg;
    end
    if (state_d == StShowHi) begin
      dp_d = 1'b1;
    end
  end

  // Registered outputs; reset blanks them immediately.
  always_ff @(posedge SC_SEVENSEG_CLOCK_50 or negedge SC_SEVENSEG_RESET_InLow) begin
    if (!SC_SEVENSEG_RESET_InLow) begin
      seg_q  <= 7'h00;
      dp_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      busy_q <= busy_d;
    end
  end

  assign SC_SEVENSEG_segments_OutBUS = seg_q;
  assign SC_SEVENSEG_dp_Out          = dp_q;
  assign SC_SEVENSEG_busy_Out        = busy_q;

endmodule
